bcd_down_timer: RTL and testbench

//  Multi-digit synchronous BCD decade DOWN counter with preset load, pause, auto-reload, and terminal flag.
//  It is the down-counting counterpart of the team's decade up counter: it counts a loaded BCD value

---
 rtl/bcd_down_timer_if.sv | 24 ++
 rtl/bcd_down_timer.sv | 117 +++++++++++
 tb/tb_bcd_down_timer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD down timer: commands and preset in, count and flags out.
interface bcd_down_timer_if #(
   parameter int DIGITS = 2
);
   logic                  start;
   logic                  stop;
   logic                  pause;
   logic                  auto_reload;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   q;
   logic                  running;
   logic                  expired;
   logic                  load_err;

   modport master (
      output start, stop, pause, auto_reload, load_val,
      input  q, running, expired, load_err
   );

   modport slave (
      input  start, stop, pause, auto_reload, load_val,
      output q, running, expired, load_err
   );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with preset load, pause, prescaled ticks,
// optional auto-reload on expiry and a sticky flag for rejected (non-BCD) presets.
module bcd_down_timer #(
   parameter int DIGITS   = 2,
   parameter int PRESCALE = 1
) (
   input  logic               clk,
   input  logic               reset,
   bcd_down_timer_if.slave    bus
);
   localparam int W  = 4 * DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    q_q, q_d;
   logic [W-1:0]    reload_q, reload_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            expired_q, expired_d;
   logic            load_err_q, load_err_d;

   logic [W-1:0]      q_dec;
   logic [DIGITS-1:0] borrow;
   logic [DIGITS-1:0] digit_ok;
   logic              load_ok;
   logic              tick;
   logic              q_zero;

   // Borrow enters digit 0 and ripples up through every digit that is currently zero.
   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] cur;
         assign cur = q_q[4*gi +: 4];
         assign q_dec[4*gi +: 4] = borrow[gi] ? ((cur == 4'd0) ? 4'd9 : cur - 4'd1) : cur;
         assign digit_ok[gi] = (bus.load_val[4*gi +: 4] <= 4'd9);
         if (gi < DIGITS - 1) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] & (cur == 4'd0);
         end
      end
   endgenerate

   assign load_ok = &digit_ok;
   assign q_zero  = (q_q == '0);
   assign tick    = (presc_q == PW'(PRESCALE - 1));

   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      reload_d   = reload_q;
      presc_d    = presc_q;
      expired_d  = 1'b0;
      load_err_d = load_err_q;

      if (bus.stop) begin
         state_d = S_IDLE;
         presc_d = '0;
      end else if (bus.start) begin
         if (load_ok) begin
            q_d        = bus.load_val;
            reload_d   = bus.load_val;
            presc_d    = '0;
            state_d    = S_RUN;
            load_err_d = 1'b0;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (state_q == S_RUN && !bus.pause) begin
         if (tick) begin
            presc_d = '0;
            if (q_zero) begin
               // The tick that finds zero is the one that consumes it.
               expired_d = 1'b1;
               if (bus.auto_reload) begin
                  q_d = reload_q;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               q_d = q_dec;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         q_q        <= '0;
         reload_q   <= '0;
         presc_q    <= '0;
         expired_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         reload_q   <= reload_d;
         presc_q    <= presc_d;
         expired_q  <= expired_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.running  = (state_q == S_RUN);
   assign bus.expired  = expired_q;
   assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: three instances cover 2-digit/1x, 3-digit/1x and 2-digit/3x prescale.
module tb_bcd_down_timer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   bcd_down_timer_if #(.DIGITS(2)) ia();
   bcd_down_timer_if #(.DIGITS(3)) ib();
   bcd_down_timer_if #(.DIGITS(2)) ic();

   bcd_down_timer #(.DIGITS(2), .PRESCALE(1)) u_a (.clk(clk), .reset(reset), .bus(ia.slave));
   bcd_down_timer #(.DIGITS(3), .PRESCALE(1)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));
   bcd_down_timer #(.DIGITS(2), .PRESCALE(3)) u_c (.clk(clk), .reset(reset), .bus(ic.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2;
      checks++;
      if (ia.q !== 8'h00 || ia.running !== 1'b0 || ia.expired !== 1'b0 || ia.load_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_init q=%h run=%b exp=%b err=%b required 00/0/0/0",
                  ia.q, ia.running, ia.expired, ia.load_err);
      end
      checks++;
      if (ib.q !== 12'h000 || ic.q !== 8'h00 || ib.running !== 1'b0 || ic.running !== 1'b0) begin
         errors++;
         $display("FAIL reset_init_bc qb=%h qc=%h runb=%b runc=%b required 000/00/0/0",
                  ib.q, ic.q, ib.running, ic.running);
      end
      cyc();
      reset = 1'b1;
      cyc();
      $display("test_reset: done");
   endtask

   task automatic test_countdown();
      logic [7:0] exp_q;
      ia.load_val = 8'h12; ia.auto_reload = 1'b0; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      checks++;
      if (ia.q !== 8'h12 || ia.running !== 1'b1) begin
         errors++;
         $display("FAIL cd_load q=%h run=%b required 12/1", ia.q, ia.running);
      end
      for (int n = 11; n >= 0; n--) begin
         cyc();
         exp_q = {4'(n / 10), 4'(n % 10)};
         checks++;
         if (ia.q !== exp_q || ia.expired !== 1'b0) begin
            errors++;
            $display("FAIL cd_step q=%h exp=%b required %h/0", ia.q, ia.expired, exp_q);
         end
      end
      cyc();
      checks++;
      if (ia.expired !== 1'b1 || ia.running !== 1'b0 || ia.q !== 8'h00) begin
         errors++;
         $display("FAIL cd_expire exp=%b run=%b q=%h required 1/0/00", ia.expired, ia.running, ia.q);
      end
      cyc();
      checks++;
      if (ia.expired !== 1'b0 || ia.running !== 1'b0 || ia.q !== 8'h00) begin
         errors++;
         $display("FAIL cd_done exp=%b run=%b q=%h required 0/0/00", ia.expired, ia.running, ia.q);
      end
      $display("test_countdown: 12 -> 00 -> DONE");
   endtask

   task automatic test_borrow();
      ib.load_val = 12'h100; ib.start = 1'b1;
      cyc();
      ib.start = 1'b0;
      cyc();
      checks++;
      if (ib.q !== 12'h099) begin
         errors++;
         $display("FAIL borrow_100 q=%h required 099", ib.q);
      end
      ib.load_val = 12'h010; ib.start = 1'b1;
      cyc();
      ib.start = 1'b0;
      checks++;
      if (ib.q !== 12'h010) begin
         errors++;
         $display("FAIL borrow_load010 q=%h required 010", ib.q);
      end
      cyc();
      checks++;
      if (ib.q !== 12'h009) begin
         errors++;
         $display("FAIL borrow_010 q=%h required 009", ib.q);
      end
      ib.stop = 1'b1;
      cyc();
      ib.stop = 1'b0;
      $display("test_borrow: 100->099, 010->009");
   endtask

   task automatic test_auto_reload();
      int t;
      int pulses;
      logic [7:0] exp_q;
      logic exp_e;
      pulses = 0;
      ic.load_val = 8'h02; ic.auto_reload = 1'b1; ic.start = 1'b1;
      cyc();
      ic.start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         t = k / 3;
         exp_q = 8'(2 - (t % 3));
         exp_e = (k % 3 == 0) && (t % 3 == 0);
         if (ic.expired === 1'b1) pulses++;
         checks++;
         if (ic.q !== exp_q || ic.expired !== exp_e || ic.running !== 1'b1) begin
            errors++;
            $display("FAIL ar_cycle%0d q=%h exp=%b run=%b required %h/%b/1",
                     k, ic.q, ic.expired, ic.running, exp_q, exp_e);
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL ar_pulses count=%0d required 2", pulses);
      end
      ic.stop = 1'b1; ic.auto_reload = 1'b0;
      cyc();
      ic.stop = 1'b0;
      $display("test_auto_reload: 20 cycles, %0d expiries", pulses);
   endtask

   task automatic test_pause_priority();
      ic.load_val = 8'h06; ic.start = 1'b1;
      cyc();
      ic.start = 1'b0;
      cyc(); cyc(); cyc();
      cyc();
      checks++;
      if (ic.q !== 8'h05) begin
         errors++;
         $display("FAIL pause_pre q=%h required 05", ic.q);
      end
      ic.pause = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks++;
         if (ic.q !== 8'h05 || ic.running !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold q=%h run=%b required 05/1", ic.q, ic.running);
         end
      end
      ic.pause = 1'b0;
      cyc();
      checks++;
      if (ic.q !== 8'h05) begin
         errors++;
         $display("FAIL pause_gain q=%h required 05", ic.q);
      end
      cyc();
      checks++;
      if (ic.q !== 8'h04) begin
         errors++;
         $display("FAIL pause_lose q=%h required 04", ic.q);
      end
      ic.load_val = 8'h33; ic.start = 1'b1; ic.stop = 1'b1;
      cyc();
      ic.start = 1'b0; ic.stop = 1'b0;
      checks++;
      if (ic.q !== 8'h04 || ic.running !== 1'b0) begin
         errors++;
         $display("FAIL start_stop q=%h run=%b required 04/0", ic.q, ic.running);
      end
      ia.load_val = 8'h20; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      cyc();
      checks++;
      if (ia.q !== 8'h19) begin
         errors++;
         $display("FAIL restart_pre q=%h required 19", ia.q);
      end
      ia.load_val = 8'h15; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      checks++;
      if (ia.q !== 8'h15 || ia.running !== 1'b1) begin
         errors++;
         $display("FAIL restart q=%h run=%b required 15/1", ia.q, ia.running);
      end
      ia.stop = 1'b1;
      cyc();
      ia.stop = 1'b0;
      cyc();
      checks++;
      if (ia.q !== 8'h15 || ia.running !== 1'b0) begin
         errors++;
         $display("FAIL stop_hold q=%h run=%b required 15/0", ia.q, ia.running);
      end
      $display("test_pause_priority: pause, start+stop, restart");
   endtask

   task automatic test_invalid_load();
      ia.load_val = 8'h1A; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      checks++;
      if (ia.q !== 8'h15 || ia.running !== 1'b0 || ia.load_err !== 1'b1) begin
         errors++;
         $display("FAIL bad_load q=%h run=%b err=%b required 15/0/1", ia.q, ia.running, ia.load_err);
      end
      cyc();
      checks++;
      if (ia.load_err !== 1'b1) begin
         errors++;
         $display("FAIL bad_sticky err=%b required 1", ia.load_err);
      end
      ia.load_val = 8'h09; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      checks++;
      if (ia.q !== 8'h09 || ia.load_err !== 1'b0 || ia.running !== 1'b1) begin
         errors++;
         $display("FAIL good_load q=%h err=%b run=%b required 09/0/1", ia.q, ia.load_err, ia.running);
      end
      ia.stop = 1'b1;
      cyc();
      ia.stop = 1'b0;
      $display("test_invalid_load: 1A rejected, 09 accepted");
   endtask

   task automatic test_zero_reload();
      ia.load_val = 8'h00; ia.auto_reload = 1'b1; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if (ia.expired !== 1'b1 || ia.q !== 8'h00 || ia.running !== 1'b1) begin
            errors++;
            $display("FAIL zero_reload exp=%b q=%h run=%b required 1/00/1", ia.expired, ia.q, ia.running);
         end
      end
      ia.auto_reload = 1'b0;
      cyc();
      checks++;
      if (ia.expired !== 1'b1 || ia.running !== 1'b0) begin
         errors++;
         $display("FAIL zero_done exp=%b run=%b required 1/0", ia.expired, ia.running);
      end
      $display("test_zero_reload: reload 0 expires every tick");
   endtask

   task automatic test_async_reset();
      ia.load_val = 8'h37; ia.pause = 1'b1; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      checks++;
      if (ia.q !== 8'h37 || ia.running !== 1'b1) begin
         errors++;
         $display("FAIL ar_pre q=%h run=%b required 37/1", ia.q, ia.running);
      end
      ia.load_val = 8'h4B; ia.start = 1'b1;
      cyc();
      ia.start = 1'b0;
      #1 reset = 1'b0;
      #1;
      checks++;
      if (ia.q !== 8'h00 || ia.running !== 1'b0 || ia.expired !== 1'b0 || ia.load_err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset q=%h run=%b exp=%b err=%b required 00/0/0/0",
                  ia.q, ia.running, ia.expired, ia.load_err);
      end
      #2 reset = 1'b1;
      ia.pause = 1'b0;
      cyc(); cyc();
      checks++;
      if (ia.q !== 8'h00 || ia.running !== 1'b0) begin
         errors++;
         $display("FAIL post_reset q=%h run=%b required 00/0", ia.q, ia.running);
      end
      $display("test_async_reset: cleared without clock");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ia.start = 0; ia.stop = 0; ia.pause = 0; ia.auto_reload = 0; ia.load_val = '0;
      ib.start = 0; ib.stop = 0; ib.pause = 0; ib.auto_reload = 0; ib.load_val = '0;
      ic.start = 0; ic.stop = 0; ic.pause = 0; ic.auto_reload = 0; ic.load_val = '0;
      test_reset();
      test_countdown();
      test_borrow();
      test_auto_reload();
      test_pause_priority();
      test_invalid_load();
      test_zero_reload();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
